// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-file geometry and write-request payload for the writeback arbiter.
package regfile_wr_arbiter_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_AW    = $clog2(REG_COUNT);
    localparam int unsigned REG_DW    = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wr_req_t;

endpackage

// File: rtl/wr_hold_fifo.sv
// In-order holding buffer for port B writes with per-entry valid and
// address-match invalidation by newer port A writes.
module wr_hold_fifo
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wr_req_t                    push_req,
    input  logic                       pop,
    input  logic                       inv_en,
    input  logic [REG_AW-1:0]          inv_addr,
    input  logic [REG_AW-1:0]          raddr1,
    input  logic [REG_AW-1:0]          raddr2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_vld,
    output wr_req_t                    head_req,
    output logic                       hit1,
    output logic                       hit2
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    wr_req_t          mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    hd;
    logic [PW-1:0]    tl;
    logic [CW-1:0]    cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    // A same-edge A write also kills a matching entry being pushed: the B result is older.
    always_ff @(posedge clk) begin
        if (rst) begin
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
            vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (inv_en && vld[i] && (mem[i].addr == inv_addr)) begin
                    vld[i] <= 1'b0;
                end
            end
            if (pop) begin
                vld[hd] <= 1'b0;
                hd      <= ptr_inc(hd);
            end
            if (push) begin
                vld[tl] <= !(inv_en && (push_req.addr == inv_addr));
                tl      <= ptr_inc(tl);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tl] <= push_req;
        end
    end

    assign count    = cnt;
    assign head_vld = vld[hd];
    assign head_req = mem[hd];

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (mem[i].addr == raddr1) && (raddr1 != REG_ZERO)) hit1 = 1'b1;
            if (vld[i] && (mem[i].addr == raddr2) && (raddr2 != REG_ZERO)) hit2 = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Single-write-port regfile arbiter: port A (pipeline writeback) always wins,
// port B (long-latency results) is buffered and drained in A-idle cycles.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned DEPTH        = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [REG_AW-1:0] a_waddr,
    input  logic [REG_DW-1:0] a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_waddr,
    input  logic [REG_DW-1:0] b_wdata,
    output logic              we,
    output logic [REG_AW-1:0] waddr,
    output logic [REG_DW-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic              pend_hit1,
    output logic              pend_hit2,
    output logic              stall_req
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT+1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] starve;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          a_occ;
    logic          push;
    logic          pop;
    logic          drain;
    logic          head_vld;
    wr_req_t       head_req;
    logic          hit1;
    logic          hit2;

    assign a_occ   = a_we && (a_waddr != REG_ZERO);
    assign b_ready = !rst && (cnt < CW'(DEPTH));
    assign push    = b_valid && b_ready && (b_waddr != REG_ZERO);
    // Squashed heads retire regardless of port A; live heads need a free write port.
    assign pop     = (cnt != '0) && (!head_vld || !a_occ);
    assign drain   = (cnt != '0) && head_vld && !a_occ;
    assign cnt_nxt = cnt + CW'(push) - CW'(pop);

    wr_hold_fifo #(.DEPTH(DEPTH)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_req ({b_waddr, b_wdata}),
        .pop      (pop),
        .inv_en   (a_occ),
        .inv_addr (a_waddr),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .count    (cnt),
        .head_vld (head_vld),
        .head_req (head_req),
        .hit1     (hit1),
        .hit2     (hit2)
    );

    assign pend_hit1 = !rst && hit1;
    assign pend_hit2 = !rst && hit2;

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (!rst) begin
            if (a_occ) begin
                we    = 1'b1;
                waddr = a_waddr;
                wdata = a_wdata;
            end else if (drain) begin
                we    = 1'b1;
                waddr = head_req.addr;
                wdata = head_req.data;
            end
        end
    end

    // Starvation FSM; stall_req tracks the FORCE state as a registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            starve    <= '0;
            stall_req <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    starve    <= '0;
                    stall_req <= 1'b0;
                    if (cnt_nxt != '0) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_nxt == '0) begin
                        state  <= ST_IDLE;
                        starve <= '0;
                    end else if (drain) begin
                        starve <= '0;
                    end else if (a_occ) begin
                        if (starve + SW'(1) >= SW'(STARVE_LIMIT)) begin
                            state     <= ST_FORCE;
                            starve    <= '0;
                            stall_req <= 1'b1;
                        end else begin
                            starve <= starve + SW'(1);
                        end
                    end
                end
                ST_FORCE: begin
                    if (cnt_nxt == '0) begin
                        state     <= ST_IDLE;
                        stall_req <= 1'b0;
                    end else if (drain) begin
                        state     <= ST_WAIT;
                        stall_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    starve    <= '0;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed-vector bench for regfile_wr_arbiter: per-cycle stimulus and expected output tables.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        pend_hit1;
    logic        pend_hit2;
    logic        stall_req;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.STARVE_LIMIT(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_we      (a_we),
        .a_waddr   (a_waddr),
        .a_wdata   (a_wdata),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_waddr   (b_waddr),
        .b_wdata   (b_wdata),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .pend_hit1 (pend_hit1),
        .pend_hit2 (pend_hit2),
        .stall_req (stall_req)
    );

    typedef struct packed {
        logic        rst;
        logic        a_we;
        logic [4:0]  a_waddr;
        logic [31:0] a_wdata;
        logic        b_valid;
        logic [4:0]  b_waddr;
        logic [31:0] b_wdata;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
    } stim_t;

    // Field order: we, waddr, wdata, b_ready, pend_hit1, pend_hit2, stall_req.
    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        b_ready;
        logic        ph1;
        logic        ph2;
        logic        stall;
    } exp_t;

    exp_t obs;
    assign obs = {we, waddr, wdata, b_ready, pend_hit1, pend_hit2, stall_req};

    int vecs = 0;
    int errs = 0;

    // Regfile image and event counters built from the write port.
    logic [31:0] rf [32];
    int b7_stale_wr = 0;
    int ghost_wr    = 0;
    int proto_viol  = 0;

    always @(posedge clk) begin
        if (we) rf[waddr] <= wdata;
        if (we && waddr == 5'd7 && wdata == 32'h1) b7_stale_wr <= b7_stale_wr + 1;
        if (we && (waddr == 5'd20 || waddr == 5'd21)) ghost_wr <= ghost_wr + 1;
        if (!rst && stall_req && a_we && a_waddr != 5'd0) proto_viol <= proto_viol + 1;
    end

    function automatic stim_t st(input logic r, input logic aw, input logic [4:0] aa,
                                 input logic [31:0] ad, input logic bv, input logic [4:0] ba,
                                 input logic [31:0] bd, input logic [4:0] r1, input logic [4:0] r2);
        return {r, aw, aa, ad, bv, ba, bd, r1, r2};
    endfunction

    function automatic exp_t ex(input logic w, input logic [4:0] a, input logic [31:0] d,
                                input logic br, input logic p1, input logic p2, input logic sr);
        return {w, a, d, br, p1, p2, sr};
    endfunction

    task automatic apply(input stim_t s);
        rst     = s.rst;
        a_we    = s.a_we;
        a_waddr = s.a_waddr;
        a_wdata = s.a_wdata;
        b_valid = s.b_valid;
        b_waddr = s.b_waddr;
        b_wdata = s.b_wdata;
        raddr1  = s.raddr1;
        raddr2  = s.raddr2;
    endtask

    task automatic test_reset();
        stim_t s[3];
        exp_t  e[3];
        s[0] = st(1, 1, 3, 32'h11, 1, 5, 32'hAA, 5, 3); e[0] = ex(0, 0, 0, 0, 0, 0, 0);
        s[1] = st(1, 1, 3, 32'h11, 1, 5, 32'hAA, 5, 3); e[1] = ex(0, 0, 0, 0, 0, 0, 0);
        s[2] = st(0, 0, 0, 0,      0, 0, 0,      0, 0); e[2] = ex(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); apply(s[i]); #1;
            vecs++;
            if (obs !== e[i]) begin
                errs++;
                $display("FAIL reset[%0d] got %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_a_only();
        stim_t s[3];
        exp_t  e[3];
        s[0] = st(0, 1, 3, 32'h11, 0, 0, 0, 0, 0); e[0] = ex(1, 3, 32'h11, 1, 0, 0, 0);
        s[1] = st(0, 1, 0, 32'h99, 0, 0, 0, 0, 0); e[1] = ex(0, 0, 0,      1, 0, 0, 0);
        s[2] = st(0, 0, 3, 32'h22, 0, 0, 0, 0, 0); e[2] = ex(0, 0, 0,      1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); apply(s[i]); #1;
            vecs++;
            if (obs !== e[i]) begin
                errs++;
                $display("FAIL a_only[%0d] got %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_b_idle();
        stim_t s[5];
        exp_t  e[5];
        s[0] = st(0, 0, 0, 0, 1, 5, 32'hAA, 5, 0); e[0] = ex(0, 0, 0,      1, 0, 0, 0);
        s[1] = st(0, 0, 0, 0, 0, 0, 0,      5, 0); e[1] = ex(1, 5, 32'hAA, 1, 1, 0, 0);
        s[2] = st(0, 0, 0, 0, 0, 0, 0,      5, 0); e[2] = ex(0, 0, 0,      1, 0, 0, 0);
        s[3] = st(0, 0, 0, 0, 1, 0, 32'h33, 0, 0); e[3] = ex(0, 0, 0,      1, 0, 0, 0);
        s[4] = st(0, 0, 0, 0, 0, 0, 0,      0, 0); e[4] = ex(0, 0, 0,      1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); apply(s[i]); #1;
            vecs++;
            if (obs !== e[i]) begin
                errs++;
                $display("FAIL b_idle[%0d] got %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[5];
        exp_t  e[5];
        s[0] = st(0, 0, 0, 0, 1, 16, 32'h16, 0, 17); e[0] = ex(0, 0,  0,      1, 0, 0, 0);
        s[1] = st(0, 0, 0, 0, 1, 17, 32'h17, 0, 17); e[1] = ex(1, 16, 32'h16, 1, 0, 0, 0);
        s[2] = st(0, 0, 0, 0, 1, 18, 32'h18, 0, 17); e[2] = ex(1, 17, 32'h17, 1, 0, 1, 0);
        s[3] = st(0, 0, 0, 0, 0, 0,  0,      0, 17); e[3] = ex(1, 18, 32'h18, 1, 0, 0, 0);
        s[4] = st(0, 0, 0, 0, 0, 0,  0,      0, 17); e[4] = ex(0, 0,  0,      1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); apply(s[i]); #1;
            vecs++;
            if (obs !== e[i]) begin
                errs++;
                $display("FAIL back_to_back[%0d] got %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        stim_t s[8];
        exp_t  e[8];
        s[0] = st(0, 1, 1, 32'hA0, 1, 8,  32'h8,  9, 0); e[0] = ex(1, 1,  32'hA0, 1, 0, 0, 0);
        s[1] = st(0, 1, 1, 32'hA1, 1, 9,  32'h9,  9, 0); e[1] = ex(1, 1,  32'hA1, 1, 0, 0, 0);
        s[2] = st(0, 1, 1, 32'hA2, 1, 10, 32'h10, 9, 0); e[2] = ex(1, 1,  32'hA2, 0, 1, 0, 0);
        s[3] = st(0, 1, 1, 32'hA3, 1, 10, 32'h10, 9, 0); e[3] = ex(1, 1,  32'hA3, 0, 1, 0, 0);
        s[4] = st(0, 0, 0, 0,      1, 10, 32'h10, 9, 0); e[4] = ex(1, 8,  32'h8,  0, 1, 0, 0);
        s[5] = st(0, 0, 0, 0,      1, 10, 32'h10, 9, 0); e[5] = ex(1, 9,  32'h9,  1, 1, 0, 0);
        s[6] = st(0, 0, 0, 0,      0, 0,  0,      9, 0); e[6] = ex(1, 10, 32'h10, 1, 0, 0, 0);
        s[7] = st(0, 0, 0, 0,      0, 0,  0,      9, 0); e[7] = ex(0, 0,  0,      1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); apply(s[i]); #1;
            vecs++;
            if (obs !== e[i]) begin
                errs++;
                $display("FAIL backpressure[%0d] got %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_starvation();
        stim_t s[8];
        exp_t  e[8];
        s[0] = st(0, 1, 2, 32'hB0, 1, 12, 32'h55, 12, 13); e[0] = ex(1, 2,  32'hB0, 1, 0, 0, 0);
        s[1] = st(0, 1, 2, 32'hB1, 1, 13, 32'h66, 12, 13); e[1] = ex(1, 2,  32'hB1, 1, 1, 0, 0);
        s[2] = st(0, 1, 2, 32'hB2, 0, 0,  0,      12, 13); e[2] = ex(1, 2,  32'hB2, 0, 1, 1, 0);
        s[3] = st(0, 1, 2, 32'hB3, 0, 0,  0,      12, 13); e[3] = ex(1, 2,  32'hB3, 0, 1, 1, 0);
        s[4] = st(0, 1, 2, 32'hB4, 0, 0,  0,      12, 13); e[4] = ex(1, 2,  32'hB4, 0, 1, 1, 0);
        s[5] = st(0, 0, 0, 0,      0, 0,  0,      12, 13); e[5] = ex(1, 12, 32'h55, 0, 1, 1, 1);
        s[6] = st(0, 0, 0, 0,      0, 0,  0,      12, 13); e[6] = ex(1, 13, 32'h66, 1, 0, 1, 0);
        s[7] = st(0, 0, 0, 0,      0, 0,  0,      12, 13); e[7] = ex(0, 0,  0,      1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); apply(s[i]); #1;
            vecs++;
            if (obs !== e[i]) begin
                errs++;
                $display("FAIL starvation[%0d] got %h expected %h", i, obs, e[i]);
            end
        end
        vecs++;
        if (proto_viol !== 0) begin
            errs++;
            $display("FAIL stall_protocol got %0d A writes under stall_req expected 0", proto_viol);
        end
    endtask

    task automatic test_squash();
        stim_t s[4];
        exp_t  e[4];
        s[0] = st(0, 1, 1, 32'hC0, 1, 7, 32'h1, 0, 7); e[0] = ex(1, 1, 32'hC0, 1, 0, 0, 0);
        s[1] = st(0, 1, 7, 32'h2,  0, 0, 0,     0, 7); e[1] = ex(1, 7, 32'h2,  1, 0, 1, 0);
        s[2] = st(0, 0, 0, 0,      0, 0, 0,     0, 7); e[2] = ex(0, 0, 0,      1, 0, 0, 0);
        s[3] = st(0, 0, 0, 0,      0, 0, 0,     0, 7); e[3] = ex(0, 0, 0,      1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); apply(s[i]); #1;
            vecs++;
            if (obs !== e[i]) begin
                errs++;
                $display("FAIL squash[%0d] got %h expected %h", i, obs, e[i]);
            end
        end
        vecs++;
        if (rf[7] !== 32'h2) begin
            errs++;
            $display("FAIL squash_r7 got %h expected 00000002", rf[7]);
        end
        vecs++;
        if (b7_stale_wr !== 0) begin
            errs++;
            $display("FAIL squash_stale got %0d stale r7 writes expected 0", b7_stale_wr);
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[5];
        exp_t  e[5];
        s[0] = st(0, 1, 1, 32'hD0, 1, 20, 32'h20, 20, 0); e[0] = ex(1, 1, 32'hD0, 1, 0, 0, 0);
        s[1] = st(0, 1, 1, 32'hD1, 1, 21, 32'h21, 20, 0); e[1] = ex(1, 1, 32'hD1, 1, 1, 0, 0);
        s[2] = st(1, 0, 0, 0,      0, 0,  0,      20, 0); e[2] = ex(0, 0, 0,      0, 0, 0, 0);
        s[3] = st(0, 0, 0, 0,      0, 0,  0,      20, 0); e[3] = ex(0, 0, 0,      1, 0, 0, 0);
        s[4] = st(0, 0, 0, 0,      0, 0,  0,      20, 0); e[4] = ex(0, 0, 0,      1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); apply(s[i]); #1;
            vecs++;
            if (obs !== e[i]) begin
                errs++;
                $display("FAIL reset_mid[%0d] got %h expected %h", i, obs, e[i]);
            end
        end
        vecs++;
        if (ghost_wr !== 0) begin
            errs++;
            $display("FAIL reset_mid_lost got %0d writes to r20/r21 expected 0", ghost_wr);
        end
    endtask

    initial begin
        apply(st(1, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_a_only();
        test_b_idle();
        test_back_to_back();
        test_backpressure();
        test_starvation();
        test_squash();
        test_reset_mid();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
